// File: rtl/draw_title_if.sv
// ============================================================================
// vga_if : pixel-stream bundle shared by the overlay drawer chain.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_if;
   logic [10:0] vcount;
   logic [10:0] hcount;
   logic        vsync;
   logic        hsync;
   logic        vblnk;
   logic        hblnk;
   logic [11:0] rgb;

   modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
   modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

`default_nettype wire

// File: rtl/draw_title.sv
// ============================================================================
// draw_title : animated block-letter banner overlay, 2-clk pass-through pipe.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module draw_title #(
   parameter int                     N_CHARS      = 9,
   parameter logic [5*N_CHARS-1:0]   TEXT         = {5'd2, 5'd12, 5'd1, 5'd3, 5'd11,
                                                     5'd10, 5'd1, 5'd3, 5'd11},
   parameter int                     XPOS         = 222,
   parameter int                     YPOS         = 100,
   parameter int                     SCALE_LOG2   = 2,
   parameter logic [11:0]            FG_RGB       = 12'hfa5,
   parameter logic [7:0]             ENABLE_MASK  = 8'b0100_0001,
   parameter int                     BLINK_FRAMES = 30,
   parameter int                     SLIDE_START  = 400,
   parameter int                     SLIDE_STEP   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] state,
   input  logic [1:0] mode,
   vga_if.in          vga_in,
   vga_if.out         vga_out
);

   localparam int c_box_w = (N_CHARS * 8) << SCALE_LOG2;
   localparam int c_box_h = 8 << SCALE_LOG2;

   // ---------------- animation state ----------------
   logic        r_vblnk_q;
   logic        r_en_q;
   logic [1:0]  r_mode_q;
   logic [15:0] r_frame_cnt;
   logic        r_vis;
   logic [11:0] r_offset;

   logic        w_en;
   logic        w_tick;
   logic        w_restart;
   logic [11:0] w_off;

   assign w_en      = ENABLE_MASK[state];
   assign w_tick    = vga_in.vblnk & ~r_vblnk_q;
   assign w_restart = (w_en & ~r_en_q) | (mode != r_mode_q);
   assign w_off     = (mode == 2'd2) ? r_offset : 12'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vblnk_q   <= 1'b0;
         r_en_q      <= 1'b0;
         r_mode_q    <= 2'd0;
         r_frame_cnt <= 16'd0;
         r_vis       <= 1'b1;
         r_offset    <= 12'(SLIDE_START);
      end else begin
         r_vblnk_q <= vga_in.vblnk;
         r_en_q    <= w_en;
         r_mode_q  <= mode;
         if (w_restart) begin
            r_frame_cnt <= 16'd0;
            r_vis       <= 1'b1;
            r_offset    <= 12'(SLIDE_START);
         end else if (mode == 2'd1) begin
            if (w_tick) begin
               if (r_frame_cnt == 16'(BLINK_FRAMES - 1)) begin
                  r_frame_cnt <= 16'd0;
                  r_vis       <= ~r_vis;
               end else begin
                  r_frame_cnt <= r_frame_cnt + 16'd1;
               end
            end
         end else if (mode == 2'd2) begin
            if (w_tick) begin
               r_offset <= (r_offset > 12'(SLIDE_STEP)) ? r_offset - 12'(SLIDE_STEP) : 12'd0;
            end
         end else begin
            r_frame_cnt <= 16'd0;
            r_vis       <= 1'b1;
            r_offset    <= 12'd0;
         end
      end
   end

   // ---------------- stage 1: box geometry ----------------
   logic [11:0] w_dx;
   logic [11:0] w_dy;

   // Left of the box wraps to a huge unsigned dx, which the compare rejects.
   assign w_dx = {1'b0, vga_in.hcount} - (12'(XPOS) + w_off);
   assign w_dy = {1'b0, vga_in.vcount} - 12'(YPOS);

   logic [10:0] r1_vcount, r1_hcount;
   logic        r1_vsync, r1_hsync, r1_vblnk, r1_hblnk;
   logic [11:0] r1_rgb;
   logic        r1_in_box;
   logic [3:0]  r1_idx;
   logic [2:0]  r1_col, r1_row;
   logic        r1_draw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_vcount <= 11'd0;
         r1_hcount <= 11'd0;
         r1_vsync  <= 1'b0;
         r1_hsync  <= 1'b0;
         r1_vblnk  <= 1'b0;
         r1_hblnk  <= 1'b0;
         r1_rgb    <= 12'd0;
         r1_in_box <= 1'b0;
         r1_idx    <= 4'd0;
         r1_col    <= 3'd0;
         r1_row    <= 3'd0;
         r1_draw   <= 1'b0;
      end else begin
         r1_vcount <= vga_in.vcount;
         r1_hcount <= vga_in.hcount;
         r1_vsync  <= vga_in.vsync;
         r1_hsync  <= vga_in.hsync;
         r1_vblnk  <= vga_in.vblnk;
         r1_hblnk  <= vga_in.hblnk;
         r1_rgb    <= vga_in.rgb;
         r1_in_box <= (w_dx < 12'(c_box_w)) && (w_dy < 12'(c_box_h));
         r1_idx    <= 4'(w_dx >> (3 + SCALE_LOG2));
         r1_col    <= 3'(w_dx >> SCALE_LOG2);
         r1_row    <= 3'(w_dy >> SCALE_LOG2);
         r1_draw   <= w_en & r_vis;
      end
   end

   // ---------------- glyph ROM ----------------
   logic [4:0] w_codes [16];

   for (genvar g = 0; g < 16; g++) begin : g_codes
      if (g < N_CHARS) begin : g_used
         assign w_codes[g] = TEXT[5*(N_CHARS-1-g) +: 5];
      end else begin : g_unused
         assign w_codes[g] = 5'd0;
      end
   end

   // Row 0 in the top five bits, leftmost column is the MSB of each row.
   function automatic logic [34:0] glyph(input logic [4:0] code);
      case (code)
         5'd1:  glyph = 35'b01110_10001_10001_11111_10001_10001_10001;
         5'd2:  glyph = 35'b11110_10001_10001_11110_10001_10001_11110;
         5'd3:  glyph = 35'b01110_10001_10000_10000_10000_10001_01110;
         5'd4:  glyph = 35'b11110_10001_10001_10001_10001_10001_11110;
         5'd5:  glyph = 35'b11111_10000_10000_11110_10000_10000_11111;
         5'd6:  glyph = 35'b11111_10000_10000_11110_10000_10000_10000;
         5'd7:  glyph = 35'b01110_10001_10000_10111_10001_10001_01111;
         5'd8:  glyph = 35'b10001_10001_10001_11111_10001_10001_10001;
         5'd9:  glyph = 35'b01110_00100_00100_00100_00100_00100_01110;
         5'd10: glyph = 35'b00111_00010_00010_00010_00010_10010_01100;
         5'd11: glyph = 35'b10001_10010_10100_11000_10100_10010_10001;
         5'd12: glyph = 35'b10000_10000_10000_10000_10000_10000_11111;
         5'd13: glyph = 35'b10001_11011_10101_10101_10001_10001_10001;
         5'd14: glyph = 35'b10001_10001_11001_10101_10011_10001_10001;
         5'd15: glyph = 35'b01110_10001_10001_10001_10001_10001_01110;
         5'd16: glyph = 35'b11110_10001_10001_11110_10000_10000_10000;
         5'd17: glyph = 35'b01110_10001_10001_10001_10101_10010_01101;
         5'd18: glyph = 35'b11110_10001_10001_11110_10100_10010_10001;
         5'd19: glyph = 35'b01111_10000_10000_01110_00001_00001_11110;
         5'd20: glyph = 35'b11111_00100_00100_00100_00100_00100_00100;
         5'd21: glyph = 35'b10001_10001_10001_10001_10001_10001_01110;
         5'd22: glyph = 35'b10001_10001_10001_10001_10001_01010_00100;
         5'd23: glyph = 35'b10001_10001_10001_10101_10101_10101_01010;
         5'd24: glyph = 35'b10001_10001_01010_00100_01010_10001_10001;
         5'd25: glyph = 35'b10001_10001_01010_00100_00100_00100_00100;
         5'd26: glyph = 35'b11111_00001_00010_00100_01000_10000_11111;
         default: glyph = 35'd0;
      endcase
   endfunction

   logic [34:0] w_glyph;
   logic [4:0]  w_row_bits;
   logic        w_bit;
   logic        w_px;

   assign w_glyph = glyph(w_codes[r1_idx]);

   always_comb begin
      w_row_bits = 5'd0;
      case (r1_row)
         3'd0: w_row_bits = w_glyph[34:30];
         3'd1: w_row_bits = w_glyph[29:25];
         3'd2: w_row_bits = w_glyph[24:20];
         3'd3: w_row_bits = w_glyph[19:15];
         3'd4: w_row_bits = w_glyph[14:10];
         3'd5: w_row_bits = w_glyph[9:5];
         3'd6: w_row_bits = w_glyph[4:0];
         default: w_row_bits = 5'd0;
      endcase
   end

   always_comb begin
      w_bit = 1'b0;
      case (r1_col)
         3'd0: w_bit = w_row_bits[4];
         3'd1: w_bit = w_row_bits[3];
         3'd2: w_bit = w_row_bits[2];
         3'd3: w_bit = w_row_bits[1];
         3'd4: w_bit = w_row_bits[0];
         default: w_bit = 1'b0;
      endcase
   end

   assign w_px = r1_in_box & w_bit;

   // ---------------- stage 2: colour mux ----------------
   logic [10:0] r2_vcount, r2_hcount;
   logic        r2_vsync, r2_hsync, r2_vblnk, r2_hblnk;
   logic [11:0] r2_rgb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r2_vcount <= 11'd0;
         r2_hcount <= 11'd0;
         r2_vsync  <= 1'b0;
         r2_hsync  <= 1'b0;
         r2_vblnk  <= 1'b0;
         r2_hblnk  <= 1'b0;
         r2_rgb    <= 12'd0;
      end else begin
         r2_vcount <= r1_vcount;
         r2_hcount <= r1_hcount;
         r2_vsync  <= r1_vsync;
         r2_hsync  <= r1_hsync;
         r2_vblnk  <= r1_vblnk;
         r2_hblnk  <= r1_hblnk;
         r2_rgb    <= (r1_draw && w_px) ? FG_RGB : r1_rgb;
      end
   end

   assign vga_out.vcount = r2_vcount;
   assign vga_out.hcount = r2_hcount;
   assign vga_out.vsync  = r2_vsync;
   assign vga_out.hsync  = r2_hsync;
   assign vga_out.vblnk  = r2_vblnk;
   assign vga_out.hblnk  = r2_hblnk;
   assign vga_out.rgb    = r2_rgb;

endmodule

`default_nettype wire

// File: tb/tb_draw_title.sv
// ============================================================================
// tb_draw_title : directed-vector bench for the draw_title overlay.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_draw_title;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] state;
   logic [1:0] mode;

   vga_if vin();
   vga_if vout();

   always #5 clk = ~clk;

   draw_title #(
      .BLINK_FRAMES (2),
      .SLIDE_START  (20),
      .SLIDE_STEP   (8)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .state   (state),
      .mode    (mode),
      .vga_in  (vin),
      .vga_out (vout)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [37:0] out_vec();
      return {vout.vcount, vout.hcount, vout.vsync, vout.hsync,
              vout.vblnk, vout.hblnk, vout.rgb};
   endfunction

   task automatic drive(input logic [37:0] v);
      {vin.vcount, vin.hcount, vin.vsync, vin.hsync, vin.vblnk, vin.hblnk, vin.rgb} = v;
   endtask

   task automatic pixel(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb);
      drive({v, h, 4'b0000, rgb});
   endtask

   task automatic probe(input string tag, input logic [10:0] h, input logic [10:0] v,
                        input logic [11:0] rgb, input bit drawn);
      pixel(h, v, rgb);
      step();
      step();
      chk(tag, 64'(vout.rgb), 64'(drawn ? 12'hfa5 : rgb));
   endtask

   task automatic frame_tick();
      vin.vblnk = 1'b1;
      step();
      vin.vblnk = 1'b0;
      step();
   endtask

   logic [37:0] vecs [6];
   logic [37:0] prev;
   int          offs [5];

   initial begin
      vecs[0] = {11'd601, 11'd1001, 1'b1, 1'b0, 1'b1, 1'b0, 12'h1a2};
      vecs[1] = {11'd17,  11'd5,    1'b0, 1'b1, 1'b0, 1'b1, 12'hb3c};
      vecs[2] = {11'd400, 11'd799,  1'b1, 1'b1, 1'b0, 1'b0, 12'h4d5};
      vecs[3] = {11'd2,   11'd1300, 1'b0, 1'b0, 1'b1, 1'b1, 12'he6f};
      vecs[4] = {11'd777, 11'd64,   1'b1, 1'b0, 1'b0, 1'b1, 12'h708};
      vecs[5] = {11'd33,  11'd250,  1'b0, 1'b1, 1'b1, 1'b0, 12'h9c1};
      offs    = '{20, 12, 4, 0, 0};

      // reset with live input
      rst_n = 1'b0;
      state = 3'd3;
      mode  = 2'd0;
      drive({11'd50, 11'd300, 4'b1111, 12'h123});
      #3;
      chk("reset_out_zero", 64'(out_vec()), 64'd0);
      step();
      step();
      chk("reset_hold_zero", 64'(out_vec()), 64'd0);
      rst_n = 1'b1;

      // 2-clk latency on every field, first sample is the cleared pipe
      prev = 38'd0;
      for (int i = 0; i < 6; i++) begin
         drive(vecs[i]);
         step();
         chk($sformatf("latency_%0d", i), 64'(out_vec()), 64'(prev));
         prev = vecs[i];
      end

      // mid-line asynchronous reset
      #2 rst_n = 1'b0;
      #1 chk("midline_reset", 64'(out_vec()), 64'd0);
      step();
      #3 rst_n = 1'b1;
      state = 3'd0;
      probe("resume_draw", 11'd222, 11'd100, 12'h321, 1'b1);

      // static drawing, state 0
      probe("B_r0c0",        11'd222, 11'd100, 12'h010, 1'b1);
      probe("left_excl",     11'd221, 11'd100, 12'h020, 1'b0);
      probe("col5_gap",      11'd242, 11'd100, 12'h030, 1'b0);
      probe("B_r1c1_hole",   11'd226, 11'd104, 12'h040, 1'b0);
      probe("L_r0c0",        11'd254, 11'd100, 12'h050, 1'b1);
      probe("L_r0c1",        11'd258, 11'd100, 12'h060, 1'b0);
      probe("K_r0c4",        11'd494, 11'd100, 12'h070, 1'b1);
      probe("right_excl",    11'd510, 11'd100, 12'h080, 1'b0);
      probe("B_r6c0",        11'd222, 11'd127, 12'h090, 1'b1);
      probe("bottom_excl",   11'd222, 11'd128, 12'h0a0, 1'b0);
      probe("above_box",     11'd222, 11'd99,  12'h0b0, 1'b0);

      // masked state passes through, even inside the box
      state = 3'd3;
      probe("mask_B",        11'd222, 11'd100, 12'h0c0, 1'b0);
      probe("mask_L",        11'd254, 11'd100, 12'h0d0, 1'b0);
      state = 3'd6;
      probe("state6_B",      11'd222, 11'd100, 12'h0e0, 1'b1);

      // blink, 2 frames on / 2 off
      state = 3'd0;
      mode  = 2'd1;
      step();
      step();
      for (int f = 0; f < 6; f++) begin
         probe($sformatf("blink_f%0d", f), 11'd222, 11'd100, 12'h111, (f < 2) || (f >= 4));
         if (f == 2) begin
            repeat (5) step();
            probe("blink_f2_mid", 11'd222, 11'd100, 12'h112, 1'b0);
         end
         frame_tick();
      end

      // slide-in, 20 -> 12 -> 4 -> 0 -> 0
      mode = 2'd2;
      step();
      step();
      for (int f = 0; f < 5; f++) begin
         probe($sformatf("slide_edge_f%0d", f), 11'(222 + offs[f]), 11'd100, 12'h222, 1'b1);
         probe($sformatf("slide_pre_f%0d", f), 11'(221 + offs[f]), 11'd100, 12'h223, 1'b0);
         frame_tick();
      end

      // restart on enable rising edge
      mode = 2'd0;
      step();
      mode = 2'd2;
      step();
      frame_tick();
      frame_tick();
      probe("slide_at4", 11'd226, 11'd100, 12'h333, 1'b1);
      state = 3'd3;
      step();
      state = 3'd0;
      step();
      probe("restart_edge",  11'd242, 11'd100, 12'h334, 1'b1);
      probe("restart_pre",   11'd241, 11'd100, 12'h335, 1'b0);

      // tick coincident with restart: restart wins
      frame_tick();
      frame_tick();
      probe("slide_at4_b", 11'd226, 11'd100, 12'h336, 1'b1);
      state = 3'd3;
      step();
      state     = 3'd0;
      vin.vblnk = 1'b1;
      step();
      vin.vblnk = 1'b0;
      step();
      probe("coinc_edge20",  11'd242, 11'd100, 12'h337, 1'b1);
      probe("coinc_not12",   11'd234, 11'd100, 12'h338, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
